// File: rtl/data_array_fill_if.sv
// rtl/data_array_fill_if.sv - core and fill port bundle for data_array_fill
interface data_array_fill_if #(
   parameter int DATA_WIDTH  = 256,
   parameter int INDEX_WIDTH = 9,
   parameter int WORD_BITS   = 3,
   parameter int BEAT_BITS   = 1
);
   localparam int BEAT_WIDTH = DATA_WIDTH / (2**BEAT_BITS);

   // core port
   logic                      a_req;
   logic                      a_we;
   logic [INDEX_WIDTH-1:0]    a_addr;
   logic [(2**WORD_BITS)-1:0] a_wmask;
   logic [DATA_WIDTH-1:0]     a_wdata;
   logic                      a_stall;
   logic                      a_rvalid;
   logic [DATA_WIDTH-1:0]     a_rdata;

   // fill port
   logic                      fill_start;
   logic [INDEX_WIDTH-1:0]    fill_addr;
   logic                      fill_valid;
   logic [BEAT_WIDTH-1:0]     fill_data;
   logic                      fill_ready;
   logic                      fill_done;

   modport master (
      output a_req, a_we, a_addr, a_wmask, a_wdata,
      input  a_stall, a_rvalid, a_rdata,
      output fill_start, fill_addr, fill_valid, fill_data,
      input  fill_ready, fill_done
   );

   modport slave (
      input  a_req, a_we, a_addr, a_wmask, a_wdata,
      output a_stall, a_rvalid, a_rdata,
      input  fill_start, fill_addr, fill_valid, fill_data,
      output fill_ready, fill_done
   );
endinterface

// File: rtl/data_array_fill.sv
// rtl/data_array_fill.sv - banked line array with masked core port and beat-wise line fill
module data_array_fill #(
   parameter int DATA_WIDTH  = 256,
   parameter int INDEX_WIDTH = 9,
   parameter int WORD_BITS   = 3,
   parameter int BEAT_BITS   = 1
) (
   input logic              clk,
   input logic              rst_n,
   data_array_fill_if.slave bus
);
   localparam int NUM_WORDS  = 2**WORD_BITS;
   localparam int WORD_WIDTH = DATA_WIDTH / NUM_WORDS;
   localparam int NUM_BEATS  = 2**BEAT_BITS;
   localparam int BEAT_WIDTH = DATA_WIDTH / NUM_BEATS;
   localparam int DEPTH      = 2**INDEX_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   state_t                 state;
   logic [BEAT_BITS-1:0]   beat_cnt;
   logic [INDEX_WIDTH-1:0] fill_idx;
   logic                   fill_ready_q;
   logic                   fill_done_q;
   logic                   rvalid_q;
   logic [DATA_WIDTH-1:0]  rdata_q;
   logic [DATA_WIDTH-1:0]  rd_line;
   logic [DATA_WIDTH-1:0]  fill_line;
   logic [BEAT_WIDTH-1:0]  fill_buf [NUM_BEATS];

   logic stall;
   logic core_acc;
   logic core_wr;
   logic core_rd;
   logic beat_acc;
   logic commit;

   // Only the line currently being filled is blocked; every other index stays open.
   assign stall    = bus.a_req && (state != S_IDLE) && (bus.a_addr == fill_idx);
   assign core_acc = bus.a_req && !stall;
   assign core_wr  = core_acc && bus.a_we;
   assign core_rd  = core_acc && !bus.a_we;
   assign beat_acc = bus.fill_valid && fill_ready_q;
   assign commit   = (state == S_COMMIT);

   assign bus.a_stall    = stall;
   assign bus.a_rvalid   = rvalid_q;
   assign bus.a_rdata    = rdata_q;
   assign bus.fill_ready = fill_ready_q;
   assign bus.fill_done  = fill_done_q;

   // Beat 0 occupies the least-significant slice of the assembled line.
   for (genvar b = 0; b < NUM_BEATS; b++) begin : g_line
      assign fill_line[b*BEAT_WIDTH +: BEAT_WIDTH] = fill_buf[b];
   end

   // One bank per word: core write is masked per word, commit writes every bank.
   for (genvar j = 0; j < NUM_WORDS; j++) begin : g_bank
      logic [WORD_WIDTH-1:0] mem [DEPTH];

      // Two independent write ports; the stall rule keeps them on different indices.
      always_ff @(posedge clk) begin
         if (core_wr && bus.a_wmask[j])
            mem[bus.a_addr] <= bus.a_wdata[j*WORD_WIDTH +: WORD_WIDTH];
         if (commit)
            mem[fill_idx] <= fill_line[j*WORD_WIDTH +: WORD_WIDTH];
      end

      assign rd_line[j*WORD_WIDTH +: WORD_WIDTH] = mem[bus.a_addr];
   end

   // Line buffer collects beats; left unreset since a reset also abandons the fill.
   always_ff @(posedge clk) begin
      if (beat_acc)
         fill_buf[beat_cnt] <= bus.fill_data;
   end

   // Registered read response; data holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= core_rd;
         if (core_rd)
            rdata_q <= rd_line;
      end
   end

   // Fill sequencer with registered ready/done; commit occupies exactly one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         beat_cnt     <= '0;
         fill_idx     <= '0;
         fill_ready_q <= 1'b0;
         fill_done_q  <= 1'b0;
      end else begin
         fill_done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.fill_start) begin
                  state        <= S_FILL;
                  fill_idx     <= bus.fill_addr;
                  beat_cnt     <= '0;
                  fill_ready_q <= 1'b1;
               end
            end
            S_FILL: begin
               if (beat_acc) begin
                  beat_cnt <= beat_cnt + BEAT_BITS'(1);
                  if (&beat_cnt) begin
                     state        <= S_COMMIT;
                     fill_ready_q <= 1'b0;
                     fill_done_q  <= 1'b1;
                  end
               end
            end
            S_COMMIT: begin
               state <= S_IDLE;
            end
            default: begin
               state        <= S_IDLE;
               fill_ready_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_data_array_fill.sv
// tb/tb_data_array_fill.sv - randomized self-checking bench for data_array_fill
module tb_data_array_fill;
   localparam int DW   = 256;
   localparam int IW   = 9;
   localparam int WB   = 3;
   localparam int BB   = 1;
   localparam int NW   = 1 << WB;
   localparam int WW   = DW / NW;
   localparam int NB   = 1 << BB;
   localparam int BW   = DW / NB;
   localparam int NIDX = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_array_fill_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .WORD_BITS(WB), .BEAT_BITS(BB)) bus ();

   data_array_fill #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .WORD_BITS(WB), .BEAT_BITS(BB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   // reference: line contents plus the outstanding fill transaction
   logic [DW-1:0] ref_mem [NIDX];
   bit            f_busy;
   bit            f_commit;
   int            f_addr;
   logic [BW-1:0] f_beats [$];
   logic          exp_rvalid;
   logic [DW-1:0] exp_rdata;
   logic [DW-1:0] init3;

   localparam logic [DW-1:0] ALL_A = {64{4'hA}};
   localparam logic [BW-1:0] B0 = {4{32'h0B00_0B00}};
   localparam logic [BW-1:0] B1 = {4{32'h1B11_1B11}};
   localparam logic [BW-1:0] B2 = {4{32'h2C22_2C22}};
   localparam logic [BW-1:0] B3 = {4{32'h3D33_3D33}};
   localparam logic [DW-1:0] PRE9 = {8{32'h9999_0009}};

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] r;
      for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic idle();
      bus.a_req      = 1'b0;
      bus.a_we       = 1'b0;
      bus.a_addr     = '0;
      bus.a_wmask    = '0;
      bus.a_wdata    = '0;
      bus.fill_start = 1'b0;
      bus.fill_addr  = '0;
      bus.fill_valid = 1'b0;
      bus.fill_data  = '0;
   endtask

   task automatic model_reset();
      f_busy     = 1'b0;
      f_commit   = 1'b0;
      f_beats.delete();
      exp_rvalid = 1'b0;
      exp_rdata  = '0;
   endtask

   // Called at a negedge with inputs set: compare outputs, advance the model over the next posedge.
   task automatic tick();
      logic          exp_stall;
      logic [DW-1:0] line;
      int            a;
      if (!rst_n) model_reset();
      #1;
      a = int'(bus.a_addr);
      exp_stall = bus.a_req && f_busy && (a == f_addr);
      check_eq("a_stall",    DW'(bus.a_stall),    DW'(exp_stall));
      check_eq("a_rvalid",   DW'(bus.a_rvalid),   DW'(exp_rvalid));
      check_eq("a_rdata",    bus.a_rdata,         exp_rdata);
      check_eq("fill_ready", DW'(bus.fill_ready), DW'(f_busy && !f_commit));
      check_eq("fill_done",  DW'(bus.fill_done),  DW'(f_commit));
      if (rst_n) begin
         exp_rvalid = 1'b0;
         if (bus.a_req && !exp_stall) begin
            if (bus.a_we) begin
               for (int j = 0; j < NW; j++)
                  if (bus.a_wmask[j]) ref_mem[a][j*WW +: WW] = bus.a_wdata[j*WW +: WW];
            end else begin
               exp_rvalid = 1'b1;
               exp_rdata  = ref_mem[a];
            end
         end
         if (f_commit) begin
            for (int b = 0; b < NB; b++) line[b*BW +: BW] = f_beats[b];
            ref_mem[f_addr] = line;
            f_busy   = 1'b0;
            f_commit = 1'b0;
            f_beats.delete();
         end else if (f_busy) begin
            if (bus.fill_valid) begin
               f_beats.push_back(bus.fill_data);
               if (f_beats.size() == NB) f_commit = 1'b1;
            end
         end else if (bus.fill_start) begin
            f_busy = 1'b1;
            f_addr = int'(bus.fill_addr);
            f_beats.delete();
         end
      end
      @(negedge clk);
   endtask

   task automatic core_wr(input int addr, input logic [NW-1:0] mask, input logic [DW-1:0] data);
      idle();
      bus.a_req   = 1'b1;
      bus.a_we    = 1'b1;
      bus.a_addr  = IW'(addr);
      bus.a_wmask = mask;
      bus.a_wdata = data;
      tick();
   endtask

   task automatic rd_expect(input int addr, input logic [DW-1:0] exp, input string tag);
      idle();
      bus.a_req  = 1'b1;
      bus.a_addr = IW'(addr);
      tick();
      check_eq({tag, "_rvalid"}, DW'(bus.a_rvalid), DW'(1'b1));
      check_eq(tag, bus.a_rdata, exp);
      idle();
      tick();
   endtask

   initial begin
      logic [DW-1:0] tmp;
      idle();
      model_reset();
      @(negedge clk);
      tick();
      check_eq("rst_rdata", bus.a_rdata, '0);
      rst_n = 1'b1;

      for (int i = 0; i < NIDX; i++) core_wr(i, '1, rand_line());
      init3 = rand_line();
      core_wr(3, '1, init3);

      // full write then read back
      core_wr(5, '1, ALL_A);
      rd_expect(5, ALL_A, "full_wr_rd");
      // single-word masked write
      core_wr(5, 8'h01, '0);
      rd_expect(5, {{7{32'hAAAA_AAAA}}, 32'h0}, "mask_wr_rd");
      // zero mask is accepted and changes nothing
      core_wr(5, 8'h00, '1);
      rd_expect(5, {{7{32'hAAAA_AAAA}}, 32'h0}, "zero_mask");

      // fill of index 9 with a gap between beats, core traffic alongside
      idle(); bus.fill_start = 1'b1; bus.fill_addr = IW'(9); tick();
      check_eq("fill_ready_hi", DW'(bus.fill_ready), DW'(1'b1));
      idle(); bus.fill_valid = 1'b1; bus.fill_data = B0; tick();
      idle(); bus.a_req = 1'b1; bus.a_addr = IW'(9); #1;
      check_eq("stall_in_fill", DW'(bus.a_stall), DW'(1'b1));
      tick();
      idle(); bus.a_req = 1'b1; bus.a_addr = IW'(3); bus.fill_valid = 1'b1; bus.fill_data = B1; #1;
      check_eq("other_idx_nostall", DW'(bus.a_stall), DW'(1'b0));
      tick();
      check_eq("fill_done_pulse", DW'(bus.fill_done), DW'(1'b1));
      check_eq("other_idx_data", bus.a_rdata, init3);
      idle(); bus.a_req = 1'b1; bus.a_addr = IW'(9); #1;
      check_eq("stall_in_commit", DW'(bus.a_stall), DW'(1'b1));
      tick();
      rd_expect(9, {B1, B0}, "fill_line");

      // reset after the first beat discards the fill
      core_wr(9, '1, PRE9);
      idle(); bus.fill_start = 1'b1; bus.fill_addr = IW'(9); tick();
      idle(); bus.fill_valid = 1'b1; bus.fill_data = B2; tick();
      idle();
      rst_n = 1'b0;
      #1;
      check_eq("rst_fill_ready", DW'(bus.fill_ready), DW'(1'b0));
      check_eq("rst_rdata_mid",  bus.a_rdata, '0);
      tick();
      rst_n = 1'b1;
      idle(); bus.fill_valid = 1'b1; bus.fill_data = B3; tick();
      idle(); tick();
      rd_expect(9, PRE9, "rst_no_commit");

      // second fill_start during FILL is ignored
      idle(); bus.fill_start = 1'b1; bus.fill_addr = IW'(9); tick();
      idle(); bus.fill_start = 1'b1; bus.fill_addr = IW'(3); bus.fill_valid = 1'b1; bus.fill_data = B2; tick();
      idle(); bus.fill_valid = 1'b1; bus.fill_data = B3; tick();
      idle(); tick();
      rd_expect(9, {B3, B2}, "refill_orig_idx");
      rd_expect(3, init3, "refill_other_idx");

      // randomized traffic against the reference
      for (int c = 0; c < 3000; c++) begin
         idle();
         rst_n = ($urandom_range(0, 399) != 0);
         bus.a_req   = $urandom_range(0, 1);
         bus.a_we    = $urandom_range(0, 1);
         bus.a_addr  = ($urandom_range(0, 3) == 0 && f_busy) ? IW'(f_addr) : IW'($urandom_range(0, NIDX-1));
         bus.a_wmask = ($urandom_range(0, 5) == 0) ? '0 : NW'($urandom());
         bus.a_wdata = rand_line();
         bus.fill_start = ($urandom_range(0, 5) == 0);
         bus.fill_addr  = IW'($urandom_range(0, NIDX-1));
         bus.fill_valid = $urandom_range(0, 1);
         tmp = rand_line();
         bus.fill_data  = tmp[BW-1:0];
         tick();
      end
      rst_n = 1'b1;
      idle();
      for (int c = 0; c < 4; c++) tick();
      for (int i = 0; i < NIDX; i++) rd_expect(i, ref_mem[i], "final_contents");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
